// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: coordinates plus sync/blanking/pulse outputs,
// driven by the timing generator and consumed by drawing stages and the DAC.
interface vga_timing_gen_if #(
    parameter int CORDW = 10
);
    logic [CORDW-1:0] x;
    logic [CORDW-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             blank_n;
    logic             sync_n;
    logic             line_start;
    logic             frame_start;

    modport master (
        output x, y, hsync, vsync, blank_n, sync_n, line_start, frame_start
    );

    modport slave (
        input  x, y, hsync, vsync, blank_n, sync_n, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator.
//
// Horizontal and vertical phase FSMs (same encoding for both axes):
//   state     | meaning
//   PH_ACTIVE | visible region, blanking released on this axis
//   PH_FRONT  | front porch, blanked
//   PH_SYNC   | sync pulse, hsync/vsync driven low
//   PH_BACK   | back porch, blanked
//
// Every registered output is decoded from the next-count value so that
// hsync/vsync/blank_n/line_start/frame_start line up with x/y on the same
// cycle. The vertical FSM only moves on a horizontal wrap.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CORDW    = 10
) (
    input  logic vgaclk,
    input  logic rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST        = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] H_FRONT_START = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] H_SYNC_START  = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] H_BACK_START  = CORDW'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [CORDW-1:0] V_LAST        = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] V_FRONT_START = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] V_SYNC_START  = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] V_BACK_START  = CORDW'(V_ACTIVE + V_FP + V_SYNC);

    // Totals must fit the coordinate width; each phase must be non-empty
    // because the FSMs leave a phase on the first count of the next one.
    if (H_TOTAL > (1 << CORDW) || V_TOTAL > (1 << CORDW)) begin : g_size_chk
        $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CORDW bits");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_phase_chk
        $error("vga_timing_gen: every timing phase needs at least one count");
    end

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FRONT  = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BACK   = 2'd3
    } phase_t;

    logic [CORDW-1:0] x_q, y_q;
    logic [CORDW-1:0] x_next, y_next;
    logic             x_wrap;
    phase_t           h_state_q, h_state_d;
    phase_t           v_state_q, v_state_d;
    logic             hsync_q, vsync_q, blank_q, line_q, frame_q;

    // Next raster position: x every clock, y on horizontal wrap.
    always_comb begin
        x_wrap = (x_q == H_LAST);
        x_next = x_q + 1'b1;
        y_next = y_q;
        if (x_wrap) begin
            x_next = '0;
            if (y_q == V_LAST) begin
                y_next = '0;
            end else begin
                y_next = y_q + 1'b1;
            end
        end
    end

    // Horizontal phase transitions keyed on the next x value.
    always_comb begin
        h_state_d = h_state_q;
        case (h_state_q)
            PH_ACTIVE: if (x_next == H_FRONT_START) h_state_d = PH_FRONT;
            PH_FRONT:  if (x_next == H_SYNC_START)  h_state_d = PH_SYNC;
            PH_SYNC:   if (x_next == H_BACK_START)  h_state_d = PH_BACK;
            PH_BACK:   if (x_next == '0)            h_state_d = PH_ACTIVE;
            default:                                h_state_d = PH_ACTIVE;
        endcase
    end

    // Vertical phase transitions keyed on the next y value, only at line wrap.
    always_comb begin
        v_state_d = v_state_q;
        if (x_wrap) begin
            case (v_state_q)
                PH_ACTIVE: if (y_next == V_FRONT_START) v_state_d = PH_FRONT;
                PH_FRONT:  if (y_next == V_SYNC_START)  v_state_d = PH_SYNC;
                PH_SYNC:   if (y_next == V_BACK_START)  v_state_d = PH_BACK;
                PH_BACK:   if (y_next == '0)            v_state_d = PH_ACTIVE;
                default:                                v_state_d = PH_ACTIVE;
            endcase
        end
    end

    // Counters, phase registers and output decode, all from next-state values.
    always_ff @(posedge vgaclk) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            h_state_q <= PH_ACTIVE;
            v_state_q <= PH_ACTIVE;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            blank_q   <= 1'b1;
            line_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            x_q       <= x_next;
            y_q       <= y_next;
            h_state_q <= h_state_d;
            v_state_q <= v_state_d;
            hsync_q   <= (h_state_d != PH_SYNC);
            vsync_q   <= (v_state_d != PH_SYNC);
            blank_q   <= (h_state_d == PH_ACTIVE) && (v_state_d == PH_ACTIVE);
            line_q    <= (x_next == '0);
            frame_q   <= (x_next == '0) && (y_next == '0);
        end
    end

    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_n     = blank_q;
    assign vga.sync_n      = 1'b0;
    assign vga.line_start  = line_q;
    assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a reduced-size instance
// (320/8/48/24 by 20/3/2/5) so whole frames fit in a short run. Expected
// outputs come from the raster position computed as cycles-since-reset
// modulo the line and frame lengths.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bn;
        logic       sn;
        logic       ls;
        logic       fs;
    } obs_t;

    localparam obs_t RST_OBS = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1,
                                 bn: 1'b1, sn: 1'b0, ls: 1'b0, fs: 1'b0};

    logic vgaclk = 1'b0;
    logic rst_a  = 1'b0;
    logic rst_b  = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    longint t_a;
    longint t_b;

    always #5 vgaclk = ~vgaclk;

    vga_timing_gen_if #(.CORDW(10)) if_a ();
    vga_timing_gen_if #(.CORDW(10)) if_b ();

    vga_timing_gen dut_a (
        .vgaclk (vgaclk),
        .rst_n  (rst_a),
        .vga    (if_a)
    );

    vga_timing_gen #(
        .H_ACTIVE (320), .H_FP (8), .H_SYNC (48), .H_BP (24),
        .V_ACTIVE (20),  .V_FP (3), .V_SYNC (2),  .V_BP (5),
        .CORDW    (10)
    ) dut_b (
        .vgaclk (vgaclk),
        .rst_n  (rst_b),
        .vga    (if_b)
    );

    obs_t obs_a, obs_b;
    assign obs_a = {if_a.x, if_a.y, if_a.hsync, if_a.vsync, if_a.blank_n,
                    if_a.sync_n, if_a.line_start, if_a.frame_start};
    assign obs_b = {if_b.x, if_b.y, if_b.hsync, if_b.vsync, if_b.blank_n,
                    if_b.sync_n, if_b.line_start, if_b.frame_start};

    // Clocks elapsed since the last reset edge, one per instance.
    always @(posedge vgaclk) begin
        if (!rst_a) t_a <= 0; else t_a <= t_a + 1;
        if (!rst_b) t_b <= 0; else t_b <= t_b + 1;
    end

    function automatic obs_t ref_model(longint t, int ha, int hf, int hs, int hb,
                                       int va, int vf, int vs, int vb);
        obs_t r;
        int ht, vt, px, py;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        px = int'(t % longint'(ht));
        py = int'((t / longint'(ht)) % longint'(vt));
        r.x  = 10'(px);
        r.y  = 10'(py);
        r.hs = !(px >= ha + hf && px < ha + hf + hs);
        r.vs = !(py >= va + vf && py < va + vf + vs);
        r.bn = (px < ha) && (py < va);
        r.sn = 1'b0;
        r.ls = (t != 0) && (px == 0);
        r.fs = (t != 0) && (px == 0) && (py == 0);
        return r;
    endfunction

    function automatic obs_t exp_a();
        return ref_model(t_a, 640, 16, 96, 48, 480, 10, 2, 33);
    endfunction

    function automatic obs_t exp_b();
        return ref_model(t_b, 320, 8, 48, 24, 20, 3, 2, 5);
    endfunction

    task automatic tick();
        @(posedge vgaclk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) begin
            tick();
            tests++;
            if (obs_a !== RST_OBS) begin
                fails++;
                $display("FAIL reset_hold_a: got %h want %h", obs_a, RST_OBS);
            end
            tests++;
            if (obs_b !== RST_OBS) begin
                fails++;
                $display("FAIL reset_hold_b: got %h want %h", obs_b, RST_OBS);
            end
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        tick();
        tests++;
        if (obs_a.x !== 10'd1 || obs_a.y !== 10'd0) begin
            fails++;
            $display("FAIL release_a: got x=%0d y=%0d want x=1 y=0", obs_a.x, obs_a.y);
        end
        tests++;
        if (obs_b.x !== 10'd1 || obs_b.y !== 10'd0) begin
            fails++;
            $display("FAIL release_b: got x=%0d y=%0d want x=1 y=0", obs_b.x, obs_b.y);
        end
    endtask

    task automatic test_line();
        int hs_low = 0, hs_first = -1, hs_last = -1, bn_fall = -1;
        int ls_cnt = 0, ls_bad = 0, wrap_ok = 0, prev_x;
        logic prev_bn;
        prev_x  = int'(obs_a.x);
        prev_bn = obs_a.bn;
        for (int i = 0; i < 800; i++) begin
            tick();
            tests++;
            if (obs_a !== exp_a()) begin
                fails++;
                if (fails <= 40) $display("FAIL line_model_a: got %h want %h", obs_a, exp_a());
            end
            if (!obs_a.hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(obs_a.x);
                hs_last = int'(obs_a.x);
            end
            if (prev_bn && !obs_a.bn && bn_fall < 0) bn_fall = int'(obs_a.x);
            if (obs_a.ls) begin
                ls_cnt++;
                if (obs_a.x != 0) ls_bad++;
            end
            if (obs_a.x == 0 && prev_x == 799 && obs_a.y == 1) wrap_ok = 1;
            prev_x  = int'(obs_a.x);
            prev_bn = obs_a.bn;
        end
        tests++;
        if (hs_low != 96 || hs_first != 656 || hs_last != 751) begin
            fails++;
            $display("FAIL hsync_window: got len=%0d %0d..%0d want 96 656..751", hs_low, hs_first, hs_last);
        end
        tests++;
        if (bn_fall != 640) begin
            fails++;
            $display("FAIL blank_fall: got x=%0d want 640", bn_fall);
        end
        tests++;
        if (ls_cnt != 1 || ls_bad != 0) begin
            fails++;
            $display("FAIL line_start_line: got count=%0d off_zero=%0d want 1 0", ls_cnt, ls_bad);
        end
        tests++;
        if (wrap_ok != 1) begin
            fails++;
            $display("FAIL x_wrap: got %0d want 1 (799->0 with y 0->1)", wrap_ok);
        end
    endtask

    task automatic test_frame();
        int guard = 0;
        int vs_low = 0, vs_first = -1, vs_last = -1, bn_bad = 0;
        int ls_cnt = 0, fs_cnt = 0, fs_bad = 0, ywrap = 0, prev_y;
        logic last_fs;
        while (guard < 15000 && !obs_b.fs) begin
            tick();
            guard++;
            tests++;
            if (obs_b !== exp_b()) begin
                fails++;
                if (fails <= 40) $display("FAIL seek_model_b: got %h want %h", obs_b, exp_b());
            end
        end
        tests++;
        if (!obs_b.fs) begin
            fails++;
            $display("FAIL frame_seek: got no frame_start in %0d clocks want one", guard);
        end
        prev_y  = int'(obs_b.y);
        last_fs = 1'b0;
        for (int i = 0; i < 12000; i++) begin
            tick();
            tests++;
            if (obs_b !== exp_b()) begin
                fails++;
                if (fails <= 40) $display("FAIL frame_model_b: got %h want %h", obs_b, exp_b());
            end
            tests++;
            if (obs_a !== exp_a()) begin
                fails++;
                if (fails <= 40) $display("FAIL frame_model_a: got %h want %h", obs_a, exp_a());
            end
            if (!obs_b.vs) begin
                vs_low++;
                if (vs_first < 0) vs_first = int'(obs_b.y);
                vs_last = int'(obs_b.y);
            end
            if (obs_b.bn && obs_b.y >= 20) bn_bad++;
            if (obs_b.ls) ls_cnt++;
            if (obs_b.fs) begin
                fs_cnt++;
                if (obs_b.x != 0 || obs_b.y != 0) fs_bad++;
            end
            if (obs_b.y == 0 && prev_y == 29 && obs_b.x == 0) ywrap++;
            prev_y  = int'(obs_b.y);
            last_fs = obs_b.fs;
        end
        tests++;
        if (vs_low != 800 || vs_first != 23 || vs_last != 24) begin
            fails++;
            $display("FAIL vsync_window: got len=%0d y%0d..%0d want 800 y23..24", vs_low, vs_first, vs_last);
        end
        tests++;
        if (bn_bad != 0) begin
            fails++;
            $display("FAIL blank_vertical: got %0d visible cycles at y>=20 want 0", bn_bad);
        end
        tests++;
        if (ls_cnt != 30) begin
            fails++;
            $display("FAIL line_start_frame: got %0d want 30", ls_cnt);
        end
        tests++;
        if (fs_cnt != 1 || !last_fs || fs_bad != 0) begin
            fails++;
            $display("FAIL frame_spacing: got count=%0d at_end=%0d bad=%0d want 1 1 0", fs_cnt, last_fs, fs_bad);
        end
        tests++;
        if (ywrap != 1) begin
            fails++;
            $display("FAIL y_wrap: got %0d want 1", ywrap);
        end
    endtask

    task automatic test_param_override();
        int x_max = 0, hs_low = 0, hs_first = -1, hs_last = -1, wrap_from = -1, prev_x;
        prev_x = int'(obs_b.x);
        for (int i = 0; i < 400; i++) begin
            tick();
            tests++;
            if (obs_b !== exp_b()) begin
                fails++;
                if (fails <= 40) $display("FAIL override_model_b: got %h want %h", obs_b, exp_b());
            end
            if (int'(obs_b.x) > x_max) x_max = int'(obs_b.x);
            if (!obs_b.hs) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(obs_b.x);
                hs_last = int'(obs_b.x);
            end
            if (obs_b.x == 0) wrap_from = prev_x;
            prev_x = int'(obs_b.x);
        end
        tests++;
        if (x_max != 399 || wrap_from != 399) begin
            fails++;
            $display("FAIL override_wrap: got max=%0d from=%0d want 399 399", x_max, wrap_from);
        end
        tests++;
        if (hs_low != 48 || hs_first != 328 || hs_last != 375) begin
            fails++;
            $display("FAIL override_hsync: got len=%0d %0d..%0d want 48 328..375", hs_low, hs_first, hs_last);
        end
    endtask

    task automatic test_mid_reset();
        int guard = 0;
        while (guard < 801 && obs_a.x != 700) begin
            tick();
            guard++;
        end
        tests++;
        if (obs_a.x != 700) begin
            fails++;
            $display("FAIL mid_seek_a: got x=%0d want 700", obs_a.x);
        end
        rst_a = 1'b0;
        tick();
        tests++;
        if (obs_a !== RST_OBS) begin
            fails++;
            $display("FAIL mid_reset_a: got %h want %h", obs_a, RST_OBS);
        end
        rst_a = 1'b1;
        tick();
        tests++;
        if (obs_a.x !== 10'd1 || obs_a.y !== 10'd0) begin
            fails++;
            $display("FAIL mid_release_a: got x=%0d y=%0d want 1 0", obs_a.x, obs_a.y);
        end
        for (int r = 0; r < 6; r++) begin
            int n, k;
            n = int'($urandom_range(1, 5000));
            k = int'($urandom_range(1, 3));
            for (int i = 0; i < n; i++) begin
                tick();
                tests++;
                if (obs_b !== exp_b()) begin
                    fails++;
                    if (fails <= 40) $display("FAIL mid_model_b: got %h want %h", obs_b, exp_b());
                end
            end
            rst_b = 1'b0;
            for (int i = 0; i < k; i++) begin
                tick();
                tests++;
                if (obs_b !== RST_OBS) begin
                    fails++;
                    $display("FAIL mid_reset_b: got %h want %h", obs_b, RST_OBS);
                end
            end
            rst_b = 1'b1;
            tick();
            tests++;
            if (obs_b.x !== 10'd1 || obs_b.y !== 10'd0) begin
                fails++;
                $display("FAIL mid_release_b: got x=%0d y=%0d want 1 0", obs_b.x, obs_b.y);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 420; i++) begin
            if (i < 400) begin
                rst_a = ($urandom_range(0, 3) != 0);
                rst_b = ($urandom_range(0, 3) != 0);
            end else begin
                rst_a = 1'b1;
                rst_b = 1'b1;
            end
            tick();
            tests++;
            if (obs_a !== exp_a()) begin
                fails++;
                if (fails <= 40) $display("FAIL b2b_model_a: got %h want %h", obs_a, exp_a());
            end
            tests++;
            if (obs_b !== exp_b()) begin
                fails++;
                if (fails <= 40) $display("FAIL b2b_model_b: got %h want %h", obs_b, exp_b());
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_param_override();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Free-running VGA raster timing generator for the 25.175 MHz pixel clock domain.
- Produces the pixel coordinates x/y consumed by every sprite/shape drawing stage (start screen, game objects) and the sync/blanking signals driven to the DAC/connector.
- Single source of raster position for the whole display path; all downstream drawing logic is purely a function of its x/y.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CORDW, 10, coordinate width

Ports:
- vgaclk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  synchronous reset, active-low
- x  out  CORDW  horizontal count, 0..H_TOTAL-1 (H_TOTAL = 800)
- y  out  CORDW  vertical count, 0..V_TOTAL-1 (V_TOTAL = 525)
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- blank_n  out  1  high only inside visible area
- sync_n  out  1  composite sync for DAC, tied low (constant 0)
- line_start  out  1  one-cycle pulse when x==0
- frame_start  out  1  one-cycle pulse when x==0 && y==0

Behaviour:
- One clock (vgaclk); reset is synchronous and active-low (rst_n), sampled only on the rising edge of vgaclk.
- Counters: x increments every clock; at x==H_TOTAL-1, x wraps to 0 and y increments; at x==H_TOTAL-1 && y==V_TOTAL-1, both wrap to 0. No other wrap points.
- Arithmetic: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; both must fit in CORDW bits (elaboration check; 800/525 fit in 10).
- All outputs are registered and aligned to the same cycle as x/y, i.e. each decode is computed from the next-count value, not the current one. Zero-latency relation between x/y and hsync/vsync/blank_n/pulses.
- Horizontal phase FSM (encoded from x): ACTIVE [0,639] -> FRONT [640,655] -> SYNC [656,751] -> BACK [752,799] -> ACTIVE. Vertical FSM is identical over y: ACTIVE [0,479], FRONT [480,489], SYNC [490,491], BACK [492,524]. Vertical phase advances only on horizontal wrap.
- hsync = 0 iff H phase is SYNC; vsync = 0 iff V phase is SYNC; blank_n = 1 iff both phases are ACTIVE.
- line_start = 1 iff x==0 (and not in reset); frame_start = 1 iff x==0 && y==0 (and not in reset).
- Reset values, held every cycle rst_n==0: x=0, y=0, hsync=1, vsync=1, blank_n=1, line_start=0, frame_start=0, sync_n=0.
- First edge with rst_n==1: x=1, y=0. The first frame_start after release occurs 420000 clocks (800*525) after the release edge. The first line_start occurs 800 clocks after the release edge.
- Reset asserted mid-frame: on the next edge, the counters and outputs take their reset values regardless of phase. No partial-line completion.
- No enable input: the counter never stalls.

Test Plan:
- Reset held 5 clocks, then released -> during reset x=0, y=0, hsync=1, vsync=1, blank_n=1, pulses 0; cycle after release x=1, y=0.
- Run 1 full line -> blank_n falls at x=640; hsync low exactly for x=656..751 (96 clocks); x wraps 799->0 with y 0->1; line_start high only at x=0.
- Run 1 full frame -> vsync low exactly for y=490..491 (1600 clocks); blank_n=0 for all y>=480; y wraps 524->0 at x wrap.
- frame_start spacing -> consecutive pulses exactly 420000 clocks apart; asserted only at x=0, y=0; line_start count per frame = 525.
- Reset asserted at x=700, y=300 for 1 clock -> next cycle x=0, y=0, hsync=1, vsync=1; after release, normal sequencing resumes from x=1.
- Parameter override H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24 -> x wraps at 399; hsync low for x=328..375.
